dequant_pipe: RTL and testbench
===============================

// Module: dequant_pipe
// PURPOSE
//  Multi-lane, pipelined dequantiser. Converts LANES signed IN_W-bit integers to IEEE-754 fp32
//  and multiplies each by a software-supplied fp32 scale. Sits between the int accumulator
//  output and the fp32 activation path. Uses valid/ready flow control with full backpressure.
// PARAMETERS
//  IN_W    8  width of each input integer, two's complement; legal range 2..24, so the int->fp convert is exact
//  LANES   4  number of independent lanes processed per beat
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  scale      in   32          fp32 scale factor; sampled with each accepted beat
//  in_valid   in   1           input beat valid
//  in_ready   out  1           block can accept a beat this cycle
//  in_data    in   LANES*IN_W  lane k = in_data[k*IN_W +: IN_W]
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts a beat
//  out_data   out  LANES*32    lane k = out_data[k*32 +: 32]; fp32 result
// BEHAVIOUR
//  Reset: every stage valid bit clears immediately. out_valid=0, out_data=0, in_ready=1.
//  Reset mid-stream discards all in-flight beats; no stale beat ever emerges after reset.
//  Handshakes
//   - A beat transfers on in_valid&&in_ready (input) and out_valid&&out_ready (output).
//   - adv = !out_valid || out_ready. When adv=1 all stages shift one place. in_ready = adv.
//   - out_data is held stable while out_valid&&!out_ready. A beat is never dropped or duplicated.
//   - Order is preserved. Pipeline bubbles collapse whenever adv=1.
//  Latency: 3 cycles from input acceptance to out_valid, with no stall. Throughput: 1 beat per cycle.
//  Stage 1, convert, per lane
//   - sign = msb. mag = |x| in IN_W bits, so -2^(IN_W-1) is handled exactly.
//   - A leading-one detector gives exponent e_i = 127 + msb_pos.
//   - mag is left-aligned into a 24-bit significand with hidden 1.
//   - x==0 sets a zero flag.
//   - Scale is decoded once per beat and shared by all lanes: sign, exp, {1,frac}.
//   - Scale flags: is_zero (exp==0, denormals flushed to zero), is_inf, is_nan.
//  Stage 2, multiply
//   - 24x24 -> 48-bit significand product.
//   - sign = xs^ss. Biased exponent e = e_i + e_s - 127, held in 10 bits signed for overflow detection.
//  Stage 3, normalise/round/pack
//   - If prod[47]=1: shift right 1, e+1.
//   - Round to nearest, ties to even, using guard/sticky from the discarded bits.
//   - A rounding carry out renormalises (e+1).
//   - e>=255 -> +/-inf (0x7F800000 | sign). e<=0 -> +/-0 (no denormal outputs).
//  Special-case priority, highest first
//   - scale NaN -> 0x7FC00000
//   - scale inf and x==0 -> 0x7FC00000
//   - scale inf -> sign|0x7F800000
//   - x==0 or scale zero -> sign|0x00000000
//  Each lane is independent. Special cases in one lane do not affect other lanes.
// TESTING
//  1 in=3, scale=0x3F000000 (0.5), out_ready=1
//    -> out_valid exactly 3 cycles later, lane=0x3FC00000 (1.5)
//  2 in=-128 (IN_W=8), scale=0x3F800000
//    -> 0xC3000000
//    in=127, scale=0xBF800000
//    -> 0xC2FE0000
//  3 Rounding: in=3, scale=0x3F800001
//    -> 0x40400002 (tie rounds to even)
//  4 Special values
//    - in=4, scale=0x7F000000 -> 0x7F800000
//    - in=0, any finite scale -> 0x00000000 or 0x80000000 (sign = scale sign)
//    - scale=0x7F800000 with in=0 -> 0x7FC00000
//  5 Backpressure: stream 6 beats, out_ready=0 for 5 cycles, then 1
//    -> in_ready=0 once 3 beats are held; out_data stable while stalled
//    -> all 6 beats delivered in order, none lost
//  6 Reset mid-stream: assert rst with 2 beats in flight
//    -> out_valid=0 immediately, in_ready=1
//    -> only post-reset beats are emitted

Source files
------------

// File: rtl/dequant_pipe.sv
// Multi-lane int -> fp32 dequantiser with a shared fp32 scale.
// Three register stages (convert, multiply, normalise/round); one global advance enable.
module dequant_pipe #(
    parameter int IN_W  = 8,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           scale_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*IN_W-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*32-1:0]   out_data_o
);

    typedef enum logic [1:0] {CLS_NUM, CLS_QNAN, CLS_INF, CLS_ZERO} cls_e;

    logic adv;
    logic v1_q, v2_q, v3_q;

    assign adv         = !v3_q || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = v3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Scale is decoded once per beat; denormal scales are treated as zero.
    logic        s1_ss_q, s1_sz_q, s1_sinf_q, s1_snan_q;
    logic [7:0]  s1_se_q;
    logic [23:0] s1_sm_q;
    logic        ss_d, sz_d, sinf_d, snan_d;
    logic [7:0]  se_d;
    logic [23:0] sm_d;

    always_comb begin
        ss_d   = scale_i[31];
        se_d   = scale_i[30:23];
        sm_d   = {1'b1, scale_i[22:0]};
        sz_d   = (se_d == 8'h00);
        sinf_d = (se_d == 8'hFF) && (scale_i[22:0] == 23'd0);
        snan_d = (se_d == 8'hFF) && (scale_i[22:0] != 23'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ss_q   <= 1'b0;
            s1_sz_q   <= 1'b0;
            s1_sinf_q <= 1'b0;
            s1_snan_q <= 1'b0;
            s1_se_q   <= '0;
            s1_sm_q   <= '0;
        end else if (adv) begin
            s1_ss_q   <= ss_d;
            s1_sz_q   <= sz_d;
            s1_sinf_q <= sinf_d;
            s1_snan_q <= snan_d;
            s1_se_q   <= se_d;
            s1_sm_q   <= sm_d;
        end
    end

    logic              s1_xs_q  [LANES];
    logic              s1_xz_q  [LANES];
    logic [7:0]        s1_xe_q  [LANES];
    logic [23:0]       s1_xm_q  [LANES];
    logic              s2_sg_q  [LANES];
    cls_e              s2_cls_q [LANES];
    logic signed [9:0] s2_e_q   [LANES];
    logic [47:0]       s2_prod_q[LANES];
    logic [31:0]       out_q    [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [IN_W-1:0]   x_d, mag_d;
            logic [4:0]        pos_d;
            logic [23:0]       mag24_d, xm_d;
            logic [7:0]        xe_d;
            cls_e              cls_d;
            logic [47:0]       prod_d;
            logic [9:0]        e_d;
            logic              norm_d, guard_d, sticky_d, rnd_d;
            logic [22:0]       mant_d;
            logic [23:0]       mr_d;
            logic signed [9:0] e1_d, e2_d;
            logic [31:0]       res_d;

            // Stage 1: magnitude in IN_W bits keeps -2^(IN_W-1) exact.
            always_comb begin
                x_d   = in_data_i[gi*IN_W +: IN_W];
                mag_d = x_d[IN_W-1] ? -x_d : x_d;
                pos_d = '0;
                for (int b = 0; b < IN_W; b++) begin
                    if (mag_d[b]) pos_d = 5'(b);
                end
                mag24_d = 24'(mag_d);
                xm_d    = mag24_d << (5'd23 - pos_d);
                xe_d    = 8'd127 + 8'(pos_d);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_xs_q[gi] <= 1'b0;
                    s1_xz_q[gi] <= 1'b0;
                    s1_xe_q[gi] <= '0;
                    s1_xm_q[gi] <= '0;
                end else if (adv) begin
                    s1_xs_q[gi] <= x_d[IN_W-1];
                    s1_xz_q[gi] <= (x_d == '0);
                    s1_xe_q[gi] <= xe_d;
                    s1_xm_q[gi] <= xm_d;
                end
            end

            // Stage 2: significand product and special-case class.
            always_comb begin
                prod_d = 48'(s1_xm_q[gi]) * 48'(s1_sm_q);
                e_d    = 10'(s1_xe_q[gi]) + 10'(s1_se_q) - 10'd127;
                if (s1_snan_q)                          cls_d = CLS_QNAN;
                else if (s1_sinf_q && s1_xz_q[gi])      cls_d = CLS_QNAN;
                else if (s1_sinf_q)                     cls_d = CLS_INF;
                else if (s1_xz_q[gi] || s1_sz_q)        cls_d = CLS_ZERO;
                else                                    cls_d = CLS_NUM;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_sg_q[gi]   <= 1'b0;
                    s2_cls_q[gi]  <= CLS_ZERO;
                    s2_e_q[gi]    <= '0;
                    s2_prod_q[gi] <= '0;
                end else if (adv) begin
                    s2_sg_q[gi]   <= s1_xs_q[gi] ^ s1_ss_q;
                    s2_cls_q[gi]  <= cls_d;
                    s2_e_q[gi]    <= $signed(e_d);
                    s2_prod_q[gi] <= prod_d;
                end
            end

            // Stage 3: product lies in [1,4); normalise, round-nearest-even, pack.
            always_comb begin
                norm_d   = s2_prod_q[gi][47];
                mant_d   = norm_d ? s2_prod_q[gi][46:24] : s2_prod_q[gi][45:23];
                guard_d  = norm_d ? s2_prod_q[gi][23]    : s2_prod_q[gi][22];
                sticky_d = norm_d ? |s2_prod_q[gi][22:0] : |s2_prod_q[gi][21:0];
                rnd_d    = guard_d && (sticky_d || mant_d[0]);
                mr_d     = {1'b0, mant_d} + 24'(rnd_d);
                e1_d     = s2_e_q[gi] + (norm_d ? 10'sd1 : 10'sd0);
                e2_d     = e1_d + (mr_d[23] ? 10'sd1 : 10'sd0);
                case (s2_cls_q[gi])
                    CLS_QNAN: res_d = 32'h7FC0_0000;
                    CLS_INF:  res_d = {s2_sg_q[gi], 31'h7F80_0000};
                    CLS_ZERO: res_d = {s2_sg_q[gi], 31'h0};
                    default: begin
                        if (e2_d >= 10'sd255)     res_d = {s2_sg_q[gi], 31'h7F80_0000};
                        else if (e2_d <= 10'sd0)  res_d = {s2_sg_q[gi], 31'h0};
                        else                      res_d = {s2_sg_q[gi], e2_d[7:0], mr_d[22:0]};
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)      out_q[gi] <= '0;
                else if (adv) out_q[gi] <= res_d;
            end

            assign out_data_o[gi*32 +: 32] = out_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_dequant_pipe.sv
// Scoreboard bench for dequant_pipe: driver queues expected beats, monitor checks outputs.
module tb_dequant_pipe;
    localparam int IN_W  = 8;
    localparam int LANES = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [31:0]           scale;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*IN_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*32-1:0]   out_data;

    dequant_pipe #(.IN_W(IN_W), .LANES(LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .scale_i     (scale),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
    );

    always #5 clk = ~clk;

    logic [127:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         stalled_prev = 1'b0;
    logic [127:0] held_data;

    logic [31:0] ftab [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [127:0] ex4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] d, input logic [31:0] s, input logic [127:0] e);
        int waited = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        scale    = s;
        while (!ok && waited <= 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        if (ok) exp_q.push_back(e);
        else check("send_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("beat in  data=%h scale=%h", d, s);
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        #1;
        check("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled_prev) begin
                check("hold_valid", 128'(out_valid), 128'd1);
                check("hold_data", out_data, held_data);
            end
            if (out_valid) begin
                check("in_ready_vs_out_ready", 128'(in_ready), 128'(out_ready));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", out_data, 128'hx);
                    end else begin
                        check("out_data", out_data, exp_q.pop_front());
                        $display("beat out data=%h", out_data);
                    end
                end
            end else begin
                check("idle_in_ready", 128'(in_ready), 128'd1);
            end
            stalled_prev = out_valid && !out_ready;
            held_data    = out_data;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        int lat;
        in_valid  = 1'b0;
        in_data   = '0;
        scale     = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_data", out_data, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Latency through an empty pipe
        send(pk(3, 3, 3, 3), 32'h3F000000,
             ex4(32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000));
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'd3);
        @(posedge clk);
        #1;

        send(pk(3, -128, 127, 0), 32'h3F800000,
             ex4(32'h40400000, 32'hC3000000, 32'h42FE0000, 32'h00000000));
        send(pk(127, 0, -128, 1), 32'hBF800000,
             ex4(32'hC2FE0000, 32'h80000000, 32'h43000000, 32'hBF800000));
        send(pk(3, -3, 1, 0), 32'h3F800001,
             ex4(32'h40400002, 32'hC0400002, 32'h3F800001, 32'h00000000));
        send(pk(3, 1, 0, -3), 32'h3F800003,
             ex4(32'h40400004, 32'h3F800003, 32'h00000000, 32'hC0400004));
        send(pk(3, 0, 0, 0), 32'h3FFFFFFF,
             ex4(32'h40BFFFFF, 32'h00000000, 32'h00000000, 32'h00000000));
        send(pk(4, -4, 0, 1), 32'h7F000000,
             ex4(32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7F000000));
        send(pk(0, 1, -1, 5), 32'h7F800000,
             ex4(32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h7F800000));
        send(pk(0, 1, -1, 2), 32'h7FC00001,
             ex4(32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000));
        send(pk(5, -5, 0, 1), 32'h00000000,
             ex4(32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000));
        send(pk(5, -5, 0, 1), 32'h80000001,
             ex4(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000));
        send(pk(1, -1, 0, 3), 32'h00800000,
             ex4(32'h00800000, 32'h80800000, 32'h00000000, 32'h01400000));
        drain();

        // Backpressure: 6-beat stream with out_ready low for 5 cycles
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(pk(i + 1, -(i + 1), i + 1, 0), 32'h3F800000,
                         ex4(ftab[i], ftab[i] | 32'h80000000, ftab[i], 32'h0));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_in_ready_full", 128'(in_ready), 128'd0);
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight
        send(pk(9, 9, 9, 9), 32'h3F800000,
             ex4(32'h41100000, 32'h41100000, 32'h41100000, 32'h41100000));
        send(pk(7, 7, 7, 7), 32'h3F800000,
             ex4(32'h40E00000, 32'h40E00000, 32'h40E00000, 32'h40E00000));
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        check("midrst_out_data", out_data, 128'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", 128'(out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        send(pk(2, -2, 6, 0), 32'h3F800000,
             ex4(32'h40000000, 32'hC0000000, 32'h40C00000, 32'h00000000));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
